pulse_recover: RTL

PULSE_RECOVER -- requirements
Module: pulse_recover

---
 rtl/pulse_recover.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_recover.sv
// pulse_recover: recovers single-cycle pulses from a stretched level coming
// from a foreign clock domain, measures each pulse's high time and returns a
// 4-phase acknowledge. Highs shorter than MIN_WIDTH are rejected as glitches.
// Optional feature macro: PULSE_RECOVER_STAT_EN enables the 8-bit
// qualified-pulse counter on pulse_cnt; without it pulse_cnt is tied to 0.
module pulse_recover #(
  parameter int MIN_WIDTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             in_level,
  output logic             out_pulse,
  output logic             ack,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             glitch,
  output logic             overrun,
  output logic [7:0]       pulse_cnt
);

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MEASURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_W_C = CNT_W'(MIN_WIDTH);

  // Synchronizer flops; in_s_q is the only view of in_level used by the FSM.
  logic             sync1_q;
  logic             in_s_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] width_q, width_d;
  logic             out_pulse_q, out_pulse_d;
  logic             ack_q, ack_d;
  logic             width_valid_q, width_valid_d;
  logic             glitch_q, glitch_d;
  logic             overrun_q, overrun_d;

  // Two-flop synchronizer; resets high so a level present at reset is not seen as a rise.
  always_ff @(posedge clk1) begin
    if (rst) begin
      sync1_q <= 1'b1;
      in_s_q  <= 1'b1;
    end else begin
      sync1_q <= in_level;
      in_s_q  <= sync1_q;
    end
  end

  // Saturating increment of the width counter.
  always_comb begin
    cnt_inc_s = cnt_q;
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_W'(1);
    end
  end

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    width_d       = width_q;
    out_pulse_d   = 1'b0;
    width_valid_d = 1'b0;
    glitch_d      = 1'b0;
    overrun_d     = overrun_q;
    case (state_q)
      ST_ARM: begin
        if (!in_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (in_s_q) begin
          cnt_d = CNT_W'(1);
          // A one-cycle minimum qualifies on the very first high sample.
          if (MIN_W_C == CNT_W'(1)) begin
            state_d     = ST_HOLD;
            out_pulse_d = 1'b1;
          end else begin
            state_d = ST_MEASURE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (in_s_q) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s >= MIN_W_C) begin
            state_d     = ST_HOLD;
            out_pulse_d = 1'b1;
          end else begin
            state_d = ST_MEASURE;
          end
        end else begin
          glitch_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (in_s_q) begin
          cnt_d   = cnt_inc_s;
          state_d = ST_HOLD;
        end else begin
          width_d       = cnt_q;
          width_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase
    // Saturation while measuring is sticky until reset.
    if (((state_d == ST_MEASURE) || (state_d == ST_HOLD)) && (cnt_d == CNT_MAX)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end
    ack_d = (state_d == ST_HOLD);
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q       <= ST_ARM;
      cnt_q         <= '0;
      width_q       <= '0;
      out_pulse_q   <= 1'b0;
      ack_q         <= 1'b0;
      width_valid_q <= 1'b0;
      glitch_q      <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      width_q       <= width_d;
      out_pulse_q   <= out_pulse_d;
      ack_q         <= ack_d;
      width_valid_q <= width_valid_d;
      glitch_q      <= glitch_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_pulse   = out_pulse_q;
  assign ack         = ack_q;
  assign width       = width_q;
  assign width_valid = width_valid_q;
  assign glitch      = glitch_q;
  assign overrun     = overrun_q;

`ifdef PULSE_RECOVER_STAT_EN
  logic [7:0] pulse_cnt_q;

  // Qualified-pulse counter, wraps at 255, advances on the edge out_pulse rises.
  always_ff @(posedge clk1) begin
    if (rst) begin
      pulse_cnt_q <= 8'd0;
    end else if (out_pulse_d) begin
      pulse_cnt_q <= pulse_cnt_q + 8'd1;
    end else begin
      pulse_cnt_q <= pulse_cnt_q;
    end
  end

  assign pulse_cnt = pulse_cnt_q;
`else
  assign pulse_cnt = 8'd0;
`endif

endmodule
